// File: rtl/sta_ram_ctrl_if.sv
// Event stream and host read port of the statistics RAM controller.
// The controller takes the slave side; the event source / host take master.
interface sta_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int INC_WIDTH  = 16
);
    logic                  evt_vld;
    logic                  evt_rdy;
    logic [ADDR_WIDTH-1:0] evt_idx;
    logic [INC_WIDTH-1:0]  evt_inc;
    logic                  host_req;
    logic                  host_clr;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic                  host_ack;
    logic [DATA_WIDTH-1:0] host_data;
    logic                  init_done;

    modport master (
        output evt_vld, evt_idx, evt_inc, host_req, host_clr, host_addr,
        input  evt_rdy, host_ack, host_data, init_done
    );

    modport slave (
        input  evt_vld, evt_idx, evt_inc, host_req, host_clr, host_addr,
        output evt_rdy, host_ack, host_data, init_done
    );
endinterface

// File: rtl/sta_ram_ctrl.sv
// Read-modify-write controller for the statistics counter RAM.
// Zero-fills the RAM after reset, then serves one operation per cycle:
// either a counter increment event or a host read / read-and-clear.
// The RAM read is asynchronous, so each op reads and writes back within
// its single op-stage cycle and back-to-back ops need no forwarding.
module sta_ram_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int INC_WIDTH  = 16,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sta_ram_ctrl_if.slave         bus,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_done;

    // op stage
    logic                  op_vld;
    logic                  op_host;
    logic                  op_clr;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [INC_WIDTH-1:0]  op_inc;

    logic                  last_host;
    logic                  host_ack;
    logic [DATA_WIDTH-1:0] host_data;

    logic                  host_busy;
    logic                  host_sel;
    logic                  evt_sel;

    // Counter update: wrap modulo 2^DATA_WIDTH, or clamp at all-ones on carry-out.
    function automatic logic [DATA_WIDTH-1:0] add_inc(
        input logic [DATA_WIDTH-1:0] base,
        input logic [INC_WIDTH-1:0]  inc
    );
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, base} + {{(DATA_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
        if (SATURATE && sum[DATA_WIDTH])
            return '1;
        return sum[DATA_WIDTH-1:0];
    endfunction

    // Selection: host wins ties unless it was the last op and an event waits,
    // so both sources alternate under contention. A host op stays "in flight"
    // through its op cycle and its ack cycle, where the host drops its request.
    always_comb begin
        host_busy = (op_vld & op_host) | host_ack;
        host_sel  = init_done & bus.host_req & ~host_busy & ~(last_host & bus.evt_vld);
        evt_sel   = init_done & bus.evt_vld & ~host_sel;
    end

    assign bus.evt_rdy   = init_done & ~host_sel;
    assign bus.host_ack  = host_ack;
    assign bus.host_data = host_data;
    assign bus.init_done = init_done;

    // Control FSM: zero-fill sweep, then op issue and host acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            op_vld    <= 1'b0;
            op_host   <= 1'b0;
            last_host <= 1'b0;
            host_ack  <= 1'b0;
            host_data <= '0;
        end else begin
            host_ack <= op_vld & op_host;
            if (op_vld && op_host)
                host_data <= ram_rd_data;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    op_vld  <= host_sel | evt_sel;
                    op_host <= host_sel;
                    if (host_sel || evt_sel)
                        last_host <= host_sel;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Op-stage payload; only meaningful while op_vld is set.
    always_ff @(posedge clk) begin
        if (host_sel) begin
            op_addr <= bus.host_addr;
            op_inc  <= '0;
            op_clr  <= bus.host_clr;
        end else begin
            op_addr <= bus.evt_idx;
            op_inc  <= bus.evt_inc;
            op_clr  <= 1'b0;
        end
    end

    assign ram_rd_addr = op_addr;

    // RAM write port: zero-fill during init, otherwise the op stage write-back.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = op_addr;
        ram_wr_data = add_inc(ram_rd_data, op_inc);
        if (state == ST_INIT) begin
            ram_wr_en   = rst_n;
            ram_wr_addr = init_cnt;
            ram_wr_data = '0;
        end else if (op_vld) begin
            if (!op_host) begin
                ram_wr_en = 1'b1;
            end else if (op_clr) begin
                ram_wr_en   = 1'b1;
                ram_wr_data = '0;
            end
        end
    end

endmodule

// File: tb/tb_sta_ram_ctrl.sv
// Self-checking bench for sta_ram_ctrl: directed scenarios followed by
// random events and host read/clears against a counter-array model.
module tb_sta_ram_ctrl;
    localparam int AW  = 4;
    localparam int DW  = 64;
    localparam int IW  = 16;
    localparam bit SAT = 1'b0;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sta_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INC_WIDTH(IW)) bus ();

    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;

    // Distributed RAM: synchronous write, asynchronous read, plus a preload port.
    logic [DW-1:0] ram [16];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    end
    assign ram_rd_data = ram[ram_rd_addr];

    sta_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INC_WIDTH(IW), .SATURATE(SAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [63:0] model [16];
    logic          last_acc = 1'b0;
    logic          last_stall = 1'b0;
    logic          got_ack = 1'b0;
    logic [63:0]   last_hdata = '0;
    logic          host_active = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic          h_clr = 1'b0;
    int            hwait = 0;
    int            stall_run = 0;

    function automatic logic [63:0] m_add(input logic [63:0] a, input logic [15:0] inc);
        if (SAT && (a > ALL1 - 64'(inc))) return ALL1;
        return a + 64'(inc);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: sample handshake mid-cycle, then update the model after the edge.
    task automatic step();
        logic acc;
        logic [AW-1:0] aidx;
        logic [IW-1:0] ainc;
        @(negedge clk);
        acc  = bus.evt_vld & bus.evt_rdy;
        aidx = bus.evt_idx;
        ainc = bus.evt_inc;
        last_stall = bus.evt_vld & ~bus.evt_rdy & bus.init_done;
        if (last_stall) begin
            stall_run++;
            check("evt_starve", 64'(stall_run <= 2), 1);
        end else begin
            stall_run = 0;
        end
        @(posedge clk);
        #1;
        last_acc = acc;
        got_ack = 1'b0;
        if (host_active) hwait++;
        if (bus.host_ack) begin
            got_ack = 1'b1;
            last_hdata = bus.host_data;
            check("ack_expected", 64'(host_active), 1);
            check("host_wait", 64'(hwait <= 3), 1);
            check($sformatf("host_data[%0d]", h_addr), bus.host_data, model[h_addr]);
            if (h_clr) model[h_addr] = '0;
            bus.host_req = 1'b0;
            host_active = 1'b0;
        end
        if (acc) model[aidx] = m_add(model[aidx], ainc);
    endtask

    task automatic start_host(input logic [AW-1:0] a, input logic c);
        bus.host_addr = a;
        bus.host_clr  = c;
        bus.host_req  = 1'b1;
        h_addr = a;
        h_clr  = c;
        host_active = 1'b1;
        hwait = 0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, input logic c);
        for (int k = 0; k < 8; k++) if (host_active || got_ack) step();
        start_host(a, c);
        for (int k = 0; k < 8; k++) begin
            step();
            if (got_ack) break;
        end
        if (!got_ack) begin
            check("host_timeout", 0, 1);
            bus.host_req = 1'b0;
            host_active = 1'b0;
        end
    endtask

    task automatic send_evt(input logic [AW-1:0] idx, input logic [IW-1:0] inc);
        bus.evt_vld = 1'b1;
        bus.evt_idx = idx;
        bus.evt_inc = inc;
        for (int k = 0; k < 8; k++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) check("evt_timeout", 0, 1);
        bus.evt_vld = 1'b0;
    endtask

    initial begin
        logic [63:0] tot;
        logic [63:0] sum;
        int nclr;
        int stalls;
        int wr;

        for (int i = 0; i < 16; i++) model[i] = '0;
        bus.evt_vld = 1'b1;
        bus.evt_idx = '0;
        bus.evt_inc = 16'd1;
        bus.host_req = 1'b0;
        bus.host_clr = 1'b0;
        bus.host_addr = '0;

        // Reset state and zero-fill sweep
        repeat (3) @(posedge clk);
        #1;
        check("rst_evt_rdy", bus.evt_rdy, 0);
        check("rst_host_ack", bus.host_ack, 0);
        check("rst_host_data", bus.host_data, 0);
        check("rst_init_done", bus.init_done, 0);
        check("rst_wr_en", ram_wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("init_wr_en[%0d]", i), ram_wr_en, 1);
            check($sformatf("init_addr[%0d]", i), ram_wr_addr, i);
            check($sformatf("init_data[%0d]", i), ram_wr_data, 0);
            check($sformatf("init_rdy[%0d]", i), bus.evt_rdy, 0);
            check($sformatf("init_done_low[%0d]", i), bus.init_done, 0);
            @(posedge clk);
            #1;
        end
        bus.evt_vld = 1'b0;
        check("init_done", bus.init_done, 1);
        check("run_wr_en", ram_wr_en, 0);

        // Back-to-back events to one counter, including carry into bit 16
        send_evt(4'd3, 16'd5);
        send_evt(4'd3, 16'd7);
        send_evt(4'd3, 16'hFFFF);
        host_read(4'd3, 1'b0);
        check("t2_sum", last_hdata, 64'h1_000B);

        // Read-clears racing a continuous event stream to the same counter
        tot = 64'h1_000B;
        sum = '0;
        nclr = 0;
        stalls = 0;
        bus.evt_vld = 1'b1;
        bus.evt_idx = 4'd3;
        bus.evt_inc = IW'($urandom_range(0, 65535));
        for (int c = 0; c < 30; c++) begin
            if (!host_active && !got_ack && nclr < 2) start_host(4'd3, 1'b1);
            step();
            if (last_stall) stalls++;
            if (got_ack) begin
                sum += last_hdata;
                nclr++;
            end
            if (last_acc) begin
                tot += 64'(bus.evt_inc);
                bus.evt_inc = IW'($urandom_range(0, 65535));
            end
        end
        bus.evt_vld = 1'b0;
        host_read(4'd3, 1'b0);
        check("t3_clears", nclr, 2);
        check("t3_stalls", stalls, 2);
        check("t3_total", sum + last_hdata, tot);

        // Counter near the top of its range
        pre_addr = 4'd9;
        pre_data = 64'hFFFF_FFFF_FFFF_FFF0;
        pre_en = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        model[9] = 64'hFFFF_FFFF_FFFF_FFF0;
        send_evt(4'd9, 16'h0020);
        host_read(4'd9, 1'b0);
        check("t4_overflow", last_hdata, SAT ? ALL1 : 64'h10);

        // Reset in the middle of a host read-clear
        send_evt(4'd5, 16'h0042);
        start_host(4'd5, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_host_ack", bus.host_ack, 0);
        check("rst2_wr_en", ram_wr_en, 0);
        check("rst2_init_done", bus.init_done, 0);
        check("rst2_evt_rdy", bus.evt_rdy, 0);
        bus.host_req = 1'b0;
        host_active = 1'b0;
        got_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst2_no_ack", bus.host_ack, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        #1;
        wr = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.init_done) break;
            if (ram_wr_en) wr++;
            check("rst2_no_ack_init", bus.host_ack, 0);
            @(negedge clk);
            #1;
        end
        check("rst2_reinit_writes", wr, 16);
        check("rst2_init_done", bus.init_done, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) host_read(AW'(i), 1'b0);

        // Random events and host reads/clears
        bus.evt_vld = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.evt_vld && $urandom_range(0, 3) != 0) begin
                bus.evt_vld = 1'b1;
                bus.evt_idx = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                          : AW'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       bus.evt_inc = 16'h0000;
                    1:       bus.evt_inc = 16'hFFFF;
                    default: bus.evt_inc = IW'($urandom_range(0, 65535));
                endcase
            end
            if (!host_active && !got_ack && $urandom_range(0, 5) == 0)
                start_host(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            step();
            if (last_acc) bus.evt_vld = 1'b0;
        end
        bus.evt_vld = 1'b0;
        for (int i = 0; i < 16; i++) host_read(AW'(i), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
